// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  // Index to one-hot grant vector.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N'(1) << idx;
  endfunction

  // 8-to-3 encoder; anything that is not exactly one-hot encodes to 0.
  function automatic logic [IDX_W-1:0] enc8(input logic [N-1:0] vec);
    logic [IDX_W-1:0] r;
    r = '0;
    if ($countones(vec) == 1) begin
      for (int i = 0; i < N; i++)
        if (vec[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [3:0]       sh;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc;

  // Rotate so ptr+1 lands at bit 0; a shift of 8 (ptr=7) is the identity.
  always_comb begin
    sh  = {1'b0, ptr} + 4'd1;
    dbl = {req, req} >> sh;
    rot = dbl[N-1:0];
  end

  // Fixed priority encoder on the rotated vector (lowest bit wins), then undo the rotation.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) enc = IDX_W'(i);
    sel = enc + ptr + IDX_W'(1);
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters, registered one-hot + encoded grant,
// grant held until done / request drop / disable / hold-limit timeout.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             owner_req;
  logic             hold_lim;
  logic             rel;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Release decision for the current owner; hold limit disabled when MAX_HOLD is 0.
  always_comb begin
    owner_req = req[gnt_idx];
    hold_lim  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    rel       = done | ~owner_req | ~en | hold_lim;
  end

  // FSM, priority pointer, hold counter and all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(N - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && any) begin
            gnt      <= onehot(sel);
            gnt_idx  <= sel;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx;
            state   <= IDLE;
            // Flag a timeout only when the hold limit alone forced the release.
            timeout <= hold_lim & ~done & owner_req & en;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // model state: owner = -1 when idle
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 7;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_edge();
    bit lim, rel;
    if (rst) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (en && req != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_hold = 0;
      end
    end else begin
      lim = (MAXH != 0) && (m_hold == MAXH - 1);
      rel = done || !req[m_owner] || !en || lim;
      if (rel) begin
        m_to    = lim && !done && req[m_owner] && en;
        m_ptr   = m_owner;
        m_owner = -1;
      end else if (m_hold < 31) begin
        m_hold++;
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    logic       inv;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    chk(tag, {19'd0, gnt, gnt_idx, gnt_vld, timeout}, {19'd0, eg, ei, (m_owner >= 0), m_to});
    inv = ($countones(gnt) <= 1) && (gnt_vld == (gnt != 8'h00)) &&
          ((gnt == 8'h00) ? (gnt_idx == 3'd0) : gnt[gnt_idx]);
    chk({tag, "_inv"}, 32'(inv), 32'd1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Async reset pulse from the negedge phase; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, "_async"});
    step({tag, "_hold"});
    rst  = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    step("reset_edge");
    step("reset_edge2");
    rst = 1'b0;
    en  = 1'b1;

    // single requester, 1-cycle latency, release on request drop
    req = 8'h01;
    step("t1_grant");
    chk("t1_gnt", 32'(gnt), 32'h01);
    chk("t1_idx", 32'(gnt_idx), 32'd0);
    req = 8'h00;
    step("t1_drop");
    chk("t1_vld", 32'(gnt_vld), 32'd0);

    // all requesting with done pulses: 0..7 then 0, one dead cycle each
    pulse_reset("t2_rst");
    req = 8'hFF;
    step("t2_first");
    for (int i = 0; i <= 8; i++) begin
      chk("t2_order", 32'(gnt_idx), 32'(i % 8));
      chk("t2_vld", 32'(gnt_vld), 32'd1);
      done = 1'b1;
      step("t2_rel");
      chk("t2_dead", 32'(gnt_vld), 32'd0);
      done = 1'b0;
      step("t2_next");
    end

    // wrap: after granting 6, req 6 and 0 -> 0 first, then 6
    pulse_reset("t3_rst");
    req = 8'h40;
    step("t3_g6");
    req = 8'h00;
    step("t3_rel6");
    req = 8'h41;
    step("t3_wrap");
    chk("t3_idx0", 32'(gnt_idx), 32'd0);
    done = 1'b1;
    step("t3_rel0");
    done = 1'b0;
    step("t3_g6b");
    chk("t3_idx6", 32'(gnt_idx), 32'd6);

    // hold limit: 16 granted cycles then timeout pulse, regrant after dead cycle
    pulse_reset("t4_rst");
    req = 8'h08;
    step("t4_grant");
    for (int i = 1; i < MAXH; i++) step("t4_hold");
    chk("t4_still", 32'(gnt_idx), 32'd3);
    step("t4_expire");
    chk("t4_to", 32'(timeout), 32'd1);
    chk("t4_dead", 32'(gnt_vld), 32'd0);
    step("t4_regrant");
    chk("t4_idx", 32'(gnt_idx), 32'd3);
    chk("t4_to_clr", 32'(timeout), 32'd0);
    // done coinciding with the limit is a normal release
    for (int i = 1; i < MAXH; i++) step("t4b_hold");
    done = 1'b1;
    step("t4b_both");
    chk("t4b_no_to", 32'(timeout), 32'd0);
    done = 1'b0;

    // enable drop releases and blocks; re-enable grants after 1 cycle
    pulse_reset("t5_rst");
    req = 8'h04;
    step("t5_grant");
    en = 1'b0;
    step("t5_off");
    chk("t5_clear", 32'(gnt), 32'h00);
    step("t5_off2");
    step("t5_off3");
    en = 1'b1;
    step("t5_on");
    chk("t5_regnt", 32'(gnt), 32'h04);

    // reset mid-grant clears without an edge, arbitration restarts from ptr=7
    req = 8'h00;
    step("t6_idle");
    req = 8'h20;
    step("t6_grant");
    chk("t6_g5", 32'(gnt), 32'h20);
    pulse_reset("t6_rst");
    req = 8'h21;
    step("t6_after");
    chk("t6_idx0", 32'(gnt_idx), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'h01 << $urandom_range(0, 7);
        1:       req = 8'h00;
        default: req = 8'($urandom);
      endcase
      en   = ($urandom_range(0, 9) != 0);
      done = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 1'b0;

    // randomized long holds to exercise timeout under traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) req = 8'($urandom);
      en   = 1'b1;
      done = ($urandom_range(0, 39) == 0);
      step("rand_hold");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Samples a request vector, grants exactly one requester (one-hot plus 3-bit encoded index) and holds the grant until release.
- Rotates priority after each grant.
- Sits in front of any shared datapath that is steered by an encoded 3-bit select.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the encoded grant index.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CNT_W, 5, hold counter width; must hold MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbiter enable; 0 blocks new grants and forces release.
- req  in  8  request vector; bit i = requester i wants the resource.
- done  in  1  single-cycle release strobe from the current owner.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  binary index of the granted requester, registered; 0 when gnt_vld=0.
- gnt_vld  out  1  1 while any grant is active (equals |gnt).
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset, async, immediate:
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - state=IDLE, hold_cnt=0.
  - ptr=7, so requester 0 has top priority first.
- All outputs are registered; no combinational path from req to gnt.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, select the first set bit searching ptr+1, ptr+2, … wrapping modulo 8.
  - At the next edge: set gnt=onehot(sel), gnt_idx=sel, gnt_vld=1, hold_cnt=0, go to GRANT.
  - Latency: req high at edge k gives gnt high after edge k+1 (1 cycle).
  - Otherwise stay in IDLE with outputs 0.
- GRANT, owner=gnt_idx:
  - Release when any of: done=1, req[owner]=0, en=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release edge: gnt=0, gnt_idx=0, gnt_vld=0, ptr=owner, go to IDLE.
  - timeout=1 for that cycle only if the hold limit was the sole release cause.
  - Otherwise hold_cnt increments, saturating at its maximum.
- Exactly one dead cycle (gnt_vld=0) between consecutive grants. The next arbitration in IDLE uses the updated ptr.
- Requests from non-owners during GRANT are ignored; they are re-evaluated in IDLE.
- Simultaneous done and timeout: treat as a normal release, timeout=0.
- Wrap-around: ptr=7 searches 0..7; ptr=3 searches 4,5,6,7,0,1,2,3. A lone requester equal to ptr is still granted.
- req changing in the same cycle as the IDLE decision: the value sampled at the edge wins.
- Reset asserted mid-grant: outputs clear immediately (async). After deassertion, arbitration restarts from ptr=7.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx equals encode(gnt).
  - A requester holding req steadily is granted within 8 grant periods.

Decomposition:
- Package arb_pkg:
  - N, IDX_W, state enum {IDLE, GRANT}.
  - Function onehot(idx).
  - Function enc8(vec), the 8-to-3 encoder returning 0 for non-one-hot input.
- Sub-module rr_pick8, combinational:
  - Inputs req[7:0], ptr[2:0]; outputs sel[2:0], any.
  - Rotates req right by ptr+1, runs a fixed priority encoder, then adds ptr+1 modulo 8.
- The top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset then req=8'b0000_0001, en=1: after 1 cycle gnt=8'h01, gnt_idx=0, gnt_vld=1. Drop req: next cycle gnt=0, ptr=0.
- req=8'hFF held, done pulsed at the end of each grant: grant order is 0,1,2,…,7,0. Each grant is separated by exactly one gnt_vld=0 cycle.
- ptr=6 (after granting 6), req=8'b0100_0001: next grant is idx 0 (wrap), not 6. Then idx 6.
- MAX_HOLD=16, req=8'h08 held, no done: gnt_idx=3 for 16 cycles, then released with timeout=1 for one cycle. Re-granted to 3 after one dead cycle.
- During grant to idx 2, drop en to 0: gnt clears next edge and no new grant while en=0. Raise en with req=8'h04: granted again after 1 cycle.
- Assert rst mid-grant (gnt=8'h20): gnt, gnt_idx and gnt_vld go to 0 without a clock edge. After release, req=8'h21 is granted to idx 0 first.
